// File: rtl/i2c_addr_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_addr_seq_ctrl_if
//  Description : Bus bundle between the I2C bit-level front end and the
//                address sequencer (byte/ACK events in, strobes/address out).
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_addr_seq_ctrl_if;
  // Events from the bit-level front end
  logic        start_det;
  logic        stop_det;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        mack_valid;
  logic        mack;
  // Sequencer results toward front end and datapath
  logic        slave_ack;
  logic        sel_start_addr;
  logic        incr_addr;
  logic [15:0] start_addr;
  logic [15:0] cur_addr;
  logic        mem_we;
  logic        mem_re;
  logic        rw_mode;
  logic        busy;

  modport slave (
    input  start_det, stop_det, byte_valid, byte_data, mack_valid, mack,
    output slave_ack, sel_start_addr, incr_addr, start_addr, cur_addr,
           mem_we, mem_re, rw_mode, busy
  );

  modport master (
    output start_det, stop_det, byte_valid, byte_data, mack_valid, mack,
    input  slave_ack, sel_start_addr, incr_addr, start_addr, cur_addr,
           mem_we, mem_re, rw_mode, busy
  );
endinterface
`default_nettype wire

// File: rtl/i2c_addr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_addr_seq_ctrl
//  Description : Decodes control/address bytes of I2C flash transactions,
//                keeps the current memory address and issues write/read
//                strobes (page wrap on writes, full wrap on reads).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_addr_seq_ctrl #(
  parameter logic [6:0] DEV_ADDR  = 7'b1010000,
  parameter int         PAGE_BITS = 6
) (
  input  logic               clk,
  input  logic               rst,
  i2c_addr_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CTRL      = 3'd1,
    ADDR_HI   = 3'd2,
    ADDR_LO   = 3'd3,
    WR_DATA   = 3'd4,
    RD_DATA   = 3'd5,
    WAIT_STOP = 3'd6
  } state_t;

  localparam logic [PAGE_BITS-1:0] PAGE_ONE = 1;

  state_t      state, state_nxt;
  logic        slave_ack_q, slave_ack_nxt;
  logic        sel_q, sel_nxt;
  logic        incr_q, incr_nxt;
  logic        we_q, we_nxt;
  logic        re_q, re_nxt;
  logic        rw_q, rw_nxt;
  logic        busy_q, busy_nxt;
  logic [15:0] cur_q, cur_nxt;
  logic [15:0] start_q, start_nxt;
  logic [7:0]  hi_q, hi_nxt;
  // A write strobe is followed one cycle later by its address increment;
  // an ACKed read increment is followed one cycle later by the read strobe.
  logic        wr_pend_q, wr_pend_nxt;
  logic        rd_pend_q, rd_pend_nxt;

  logic [15:0] cur_page_inc;
  logic        ctrl_match;

  assign cur_page_inc = {cur_q[15:PAGE_BITS], cur_q[PAGE_BITS-1:0] + PAGE_ONE};
  assign ctrl_match   = (bus.byte_data[7:1] == DEV_ADDR);

  // Register all state and outputs; reset returns everything to idle values
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      slave_ack_q <= 1'b0;
      sel_q       <= 1'b0;
      incr_q      <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      cur_q       <= 16'h0000;
      start_q     <= 16'h0000;
      hi_q        <= 8'h00;
      wr_pend_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      slave_ack_q <= slave_ack_nxt;
      sel_q       <= sel_nxt;
      incr_q      <= incr_nxt;
      we_q        <= we_nxt;
      re_q        <= re_nxt;
      rw_q        <= rw_nxt;
      busy_q      <= busy_nxt;
      cur_q       <= cur_nxt;
      start_q     <= start_nxt;
      hi_q        <= hi_nxt;
      wr_pend_q   <= wr_pend_nxt;
      rd_pend_q   <= rd_pend_nxt;
    end
  end

  // Next-state and next-output decode with stop > start > byte > mack priority
  always_comb begin
    state_nxt     = state;
    slave_ack_nxt = slave_ack_q;
    sel_nxt       = 1'b0;
    incr_nxt      = 1'b0;
    we_nxt        = 1'b0;
    re_nxt        = 1'b0;
    rw_nxt        = rw_q;
    cur_nxt       = cur_q;
    start_nxt     = start_q;
    hi_nxt        = hi_q;
    wr_pend_nxt   = 1'b0;
    rd_pend_nxt   = 1'b0;

    // The byte was already written, so its address advance always completes
    if (wr_pend_q) begin
      incr_nxt = 1'b1;
      cur_nxt  = cur_page_inc;
    end
    // A read for a transaction that was just terminated is not issued
    if (rd_pend_q && !bus.stop_det && !bus.start_det) begin
      re_nxt = 1'b1;
    end

    if (bus.stop_det) begin
      state_nxt     = IDLE;
      slave_ack_nxt = 1'b0;
    end else if (bus.start_det) begin
      state_nxt     = CTRL;
      slave_ack_nxt = 1'b0;
    end else if (bus.byte_valid) begin
      case (state)
        CTRL: begin
          if (ctrl_match) begin
            slave_ack_nxt = 1'b1;
            rw_nxt        = bus.byte_data[0];
            if (bus.byte_data[0]) begin
              state_nxt = RD_DATA;
              re_nxt    = 1'b1;
            end else begin
              state_nxt = ADDR_HI;
            end
          end else begin
            slave_ack_nxt = 1'b0;
            state_nxt     = WAIT_STOP;
          end
        end
        ADDR_HI: begin
          hi_nxt        = bus.byte_data;
          slave_ack_nxt = 1'b1;
          state_nxt     = ADDR_LO;
        end
        ADDR_LO: begin
          start_nxt     = {hi_q, bus.byte_data};
          cur_nxt       = {hi_q, bus.byte_data};
          sel_nxt       = 1'b1;
          slave_ack_nxt = 1'b1;
          state_nxt     = WR_DATA;
        end
        WR_DATA: begin
          we_nxt        = 1'b1;
          slave_ack_nxt = 1'b1;
          wr_pend_nxt   = 1'b1;
        end
        WAIT_STOP: begin
          slave_ack_nxt = 1'b0;
        end
        default: begin
        end
      endcase
    end else if (bus.mack_valid && (state == RD_DATA)) begin
      if (bus.mack) begin
        incr_nxt    = 1'b1;
        cur_nxt     = cur_q + 16'd1;
        rd_pend_nxt = 1'b1;
      end else begin
        state_nxt     = WAIT_STOP;
        slave_ack_nxt = 1'b0;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.slave_ack      = slave_ack_q;
  assign bus.sel_start_addr = sel_q;
  assign bus.incr_addr      = incr_q;
  assign bus.start_addr     = start_q;
  assign bus.cur_addr       = cur_q;
  assign bus.mem_we         = we_q;
  assign bus.mem_re         = re_q;
  assign bus.rw_mode        = rw_q;
  assign bus.busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_addr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_addr_seq_ctrl
//  Description : Scoreboard bench for the I2C address sequencer. A
//                transaction-level model predicts strobes into a queue; a
//                monitor pops and compares whenever the DUT strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_addr_seq_ctrl;

  localparam int K_SEL = 0;
  localparam int K_WE  = 1;
  localparam int K_INC = 2;
  localparam int K_RE  = 3;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];

  // Transaction-level reference state
  bit          m_in, m_ign, m_rd, m_ack, m_ack_known, m_rw;
  int          m_n;
  logic [15:0] m_cur, m_start;
  logic [7:0]  m_hi;

  i2c_addr_seq_ctrl_if bus ();

  i2c_addr_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected strobes
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_strobe(input int kind, input string nm);
    exp_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected strobe at cycle %0d, cur_addr %0h", nm, cyc, bus.cur_addr);
    end else begin
      e = q.pop_front();
      check({nm, " kind"}, 32'(kind), 32'(e.kind));
      check({nm, " cycle"}, 32'(cyc), 32'(e.cyc));
      check({nm, " cur_addr"}, 32'(bus.cur_addr), 32'(e.addr));
      if (kind == K_SEL) check({nm, " start_addr"}, 32'(bus.start_addr), 32'(e.addr));
    end
  endtask

  // Monitor: flag overdue expectations, then match each strobe to the queue
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing strobe kind %0d: expected cycle %0d addr %0h, not observed",
               q[0].kind, q[0].cyc, q[0].addr);
      void'(q.pop_front());
    end
    if (bus.sel_start_addr) expect_strobe(K_SEL, "sel_start_addr");
    if (bus.mem_we)         expect_strobe(K_WE,  "mem_we");
    if (bus.incr_addr)      expect_strobe(K_INC, "incr_addr");
    if (bus.mem_re)         expect_strobe(K_RE,  "mem_re");
  end

  function automatic void push(input int kind, input logic [15:0] addr, input int c);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.cyc  = c;
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_in = 0; m_ign = 0; m_rd = 0; m_ack = 0; m_ack_known = 1; m_rw = 0;
    m_n = 0; m_cur = 16'h0000; m_start = 16'h0000; m_hi = 8'h00;
  endfunction

  // Reference model of one bus event observed at cycle t (response at t+1)
  function automatic void model_event(input bit s, input bit p, input bit bv,
                                      input logic [7:0] d, input bit mv, input bit m,
                                      input int t);
    if (p) begin
      m_in = 0; m_ack = 0; m_ack_known = 1;
    end else if (s) begin
      m_in = 1; m_n = 0; m_ign = 0; m_rd = 0; m_ack = 0; m_ack_known = 1;
    end else if (bv) begin
      if (!m_in || m_ign) begin
        m_ack = 0; m_ack_known = 1;
      end else if (!m_rd) begin
        if (m_n == 0) begin
          if (d[7:1] == 7'h50) begin
            m_ack = 1; m_rw = d[0];
            if (d[0]) begin
              m_rd = 1;
              push(K_RE, m_cur, t + 1);
            end
          end else begin
            m_ack = 0; m_ign = 1;
          end
        end else if (m_n == 1) begin
          m_hi = d; m_ack = 1;
        end else if (m_n == 2) begin
          m_start = {m_hi, d}; m_cur = m_start; m_ack = 1;
          push(K_SEL, m_start, t + 1);
        end else begin
          m_ack = 1;
          push(K_WE, m_cur, t + 1);
          // Page is 64 bytes: only the offset inside the page advances
          m_cur = (m_cur & 16'hFFC0) | ((m_cur + 16'd1) % 16'd64);
          push(K_INC, m_cur, t + 2);
        end
        m_n++;
      end
    end else if (mv && m_in && m_rd && !m_ign) begin
      if (m) begin
        m_cur = m_cur + 16'd1;
        push(K_INC, m_cur, t + 1);
        push(K_RE, m_cur, t + 2);
      end else begin
        m_ign = 1; m_ack_known = 0;
      end
    end
  endfunction

  task automatic drive(input bit s, input bit p, input bit bv, input logic [7:0] d,
                       input bit mv, input bit m, input int gap);
    int t;
    t = cyc;
    bus.start_det = s; bus.stop_det = p; bus.byte_valid = bv; bus.byte_data = d;
    bus.mack_valid = mv; bus.mack = m;
    model_event(s, p, bv, d, mv, m, t);
    @(posedge clk); #1;
    bus.start_det = 0; bus.stop_det = 0; bus.byte_valid = 0; bus.mack_valid = 0; bus.mack = 0;
    check("busy", 32'(bus.busy), 32'(m_in));
    check("rw_mode", 32'(bus.rw_mode), 32'(m_rw));
    if (m_ack_known) check("slave_ack", 32'(bus.slave_ack), 32'(m_ack));
    repeat (gap) @(posedge clk);
    #1;
    check("cur_addr", 32'(bus.cur_addr), 32'(m_cur));
    check("start_addr", 32'(bus.start_addr), 32'(m_start));
  endtask

  task automatic do_start();                  drive(1, 0, 0, 8'h00, 0, 0, 3); endtask
  task automatic do_stop();                   drive(0, 1, 0, 8'h00, 0, 0, 3); endtask
  task automatic do_byte(input logic [7:0] d); drive(0, 0, 1, d, 0, 0, 3);     endtask
  task automatic do_mack(input bit m);        drive(0, 0, 0, 8'h00, 1, m, 3); endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " slave_ack"},      32'(bus.slave_ack), 0);
    check({tag, " sel_start_addr"}, 32'(bus.sel_start_addr), 0);
    check({tag, " incr_addr"},      32'(bus.incr_addr), 0);
    check({tag, " mem_we"},         32'(bus.mem_we), 0);
    check({tag, " mem_re"},         32'(bus.mem_re), 0);
    check({tag, " rw_mode"},        32'(bus.rw_mode), 0);
    check({tag, " busy"},           32'(bus.busy), 0);
    check({tag, " cur_addr"},       32'(bus.cur_addr), 0);
    check({tag, " start_addr"},     32'(bus.start_addr), 0);
  endtask

  // Data byte followed by reset in the cycle between mem_we and incr_addr
  task automatic byte_then_reset(input logic [7:0] d);
    int t;
    t = cyc;
    bus.byte_valid = 1; bus.byte_data = d;
    push(K_WE, m_cur, t + 1);
    @(posedge clk); #1;
    bus.byte_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check_reset_outputs("mid-write rst");
    repeat (3) @(posedge clk);
    #1;
    check("post-rst cur_addr", 32'(bus.cur_addr), 0);
  endtask

  initial begin
    int r;
    logic [7:0] d;
    bus.start_det = 0; bus.stop_det = 0; bus.byte_valid = 0; bus.byte_data = 8'h00;
    bus.mack_valid = 0; bus.mack = 0;
    rst = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check_reset_outputs("reset");

    // Write with page wrap
    do_start(); do_byte(8'hA0); do_byte(8'h12); do_byte(8'h3E);
    do_byte(8'h11); do_byte(8'h22); do_byte(8'h33); do_stop();
    check("page-wrap final cur_addr", 32'(bus.cur_addr), 32'h1201);

    // Random read across the top of the array
    do_start(); do_byte(8'hA0); do_byte(8'hFF); do_byte(8'hFF);
    do_start(); do_byte(8'hA1);
    do_mack(1); do_mack(1); do_mack(0);
    do_byte(8'h5A);
    do_stop();
    check("read wrap cur_addr", 32'(bus.cur_addr), 32'h0001);

    // Wrong device address
    do_start(); do_byte(8'hA2); do_byte(8'h55); do_byte(8'h66); do_stop();

    // Aborted address write, then current-address read
    do_start(); do_byte(8'hA0); do_byte(8'h40); do_stop();
    do_start(); do_byte(8'hA1); do_mack(0); do_stop();

    // Reset between mem_we and incr_addr
    do_start(); do_byte(8'hA0); do_byte(8'h00); do_byte(8'h10);
    byte_then_reset(8'h77);

    // STOP coincident with a data byte
    do_start(); do_byte(8'hA0); do_byte(8'h00); do_byte(8'h20); do_byte(8'h11);
    drive(0, 1, 1, 8'h99, 0, 0, 3);

    // Randomised event stream
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        do_start();
      end else if (r < 14) begin
        do_stop();
      end else if (r < 70) begin
        d = 8'($urandom);
        if (m_in && !m_ign && !m_rd) begin
          if (m_n == 0) begin
            r = int'($urandom_range(0, 9));
            d = (r < 5) ? 8'hA0 : (r < 9) ? 8'hA1 : d;
          end else if (m_n == 1 && $urandom_range(0, 3) == 0) begin
            d = 8'hFF;
          end else if (m_n == 2 && $urandom_range(0, 1) == 0) begin
            d = 8'h3C + 8'($urandom_range(0, 3));
          end
        end
        do_byte(d);
      end else begin
        do_mack($urandom_range(0, 3) != 0);
      end
    end
    do_stop();

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_addr_seq_ctrl.md
# i2c_addr_seq_ctrl

Address sequencer for the I2C flash memory model. It sits between the I2C bit-level front end (START/STOP detect, byte shift register, ACK driver) and the address register/mux/adder datapath. It decodes the control and address bytes of each I2C transaction and drives the start-address select and increment strobes. It also keeps the current memory address and issues one-cycle memory write/read strobes with EEPROM-style page-wrap on writes and full-array wrap on reads.

## Interface
- DEV_ADDR, 7'b1010000, 7-bit slave address matched against control byte bits [7:1]
- PAGE_BITS, 6, log2 of write page size (64 bytes); writes wrap inside the page
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start_det  in  1  one-cycle pulse: START or repeated START seen
- stop_det  in  1  one-cycle pulse: STOP seen
- byte_valid  in  1  one-cycle pulse: byte_data holds a complete received byte
- byte_data  in  8  received byte (MSB first as shifted)
- mack_valid  in  1  one-cycle pulse: master ACK/NACK bit sampled after a read byte
- mack  in  1  1 = master ACK (continue), 0 = NACK (end of read)
- slave_ack  out  1  level; 1 = front end drives ACK in the next 9th bit
- sel_start_addr  out  1  one-cycle pulse; start_addr loaded into cur_addr
- incr_addr  out  1  one-cycle pulse; cur_addr advanced
- start_addr  out  16  last address assembled from the two address bytes
- cur_addr  out  16  current memory address
- mem_we  out  1  one-cycle write strobe; write byte_data-latched value at cur_addr
- mem_re  out  1  one-cycle read strobe at cur_addr
- rw_mode  out  1  R/W bit of last matched control byte
- busy  out  1  1 in any state other than IDLE

## Operation
- States: IDLE, CTRL, ADDR_HI, ADDR_LO, WR_DATA, RD_DATA, WAIT_STOP.
- Event priority per cycle: rst > stop_det > start_det > byte_valid > mack_valid.
- stop_det in any state: go to IDLE and clear slave_ack. cur_addr is unchanged.
- start_det in any state: go to CTRL and clear slave_ack. cur_addr is unchanged, so a repeated START after an address write gives a random read.
- CTRL, byte_valid:
  - byte_data[7:1]==DEV_ADDR: slave_ack=1, rw_mode=byte_data[0]. Write goes to ADDR_HI. Read goes to RD_DATA and issues mem_re at the current cur_addr.
  - Mismatch: slave_ack=0, go to WAIT_STOP.
- ADDR_HI, byte_valid: latch hi byte, slave_ack=1, go to ADDR_LO.
- ADDR_LO, byte_valid: start_addr={hi,byte_data}, cur_addr=start_addr, pulse sel_start_addr, slave_ack=1, go to WR_DATA.
- WR_DATA, byte_valid: pulse mem_we with the current cur_addr, slave_ack=1.
  - Next cycle: pulse incr_addr.
  - cur_addr = {cur_addr[15:PAGE_BITS], cur_addr[PAGE_BITS-1:0]+1}; the low field wraps modulo 2^PAGE_BITS and the upper bits never change.
- RD_DATA, mack_valid:
  - mack=1: pulse incr_addr, cur_addr=cur_addr+1 modulo 2^16 (0xFFFF→0x0000), then mem_re next cycle at the new address.
  - mack=0: no increment, go to WAIT_STOP.
- RD_DATA, byte_valid: ignored.
- WAIT_STOP: all byte_valid/mack_valid ignored, slave_ack=0; leaves only on stop_det or start_det.
- IDLE: byte_valid/mack_valid ignored.

## Timing
- Reset values:
  - state IDLE.
  - cur_addr, start_addr 16'h0000.
  - slave_ack, sel_start_addr, incr_addr, mem_we, mem_re, rw_mode, busy all 0.
- All outputs registered; response appears the cycle after the causing input pulse (latency 1).
- Write byte: mem_we at T+1 (byte_valid at T), incr_addr and new cur_addr at T+2. byte_valid spacing ≥3 cycles is guaranteed by the front end.
- Read: first mem_re at T+1 after control byte. After an ACKed mack_valid at T: incr_addr and new cur_addr at T+1, mem_re at T+2.
- sel_start_addr and the cur_addr load take effect in the same edge (T+1 after the low address byte).
- slave_ack holds its value until the next byte_valid, start_det or stop_det.
- rst asserted mid-transaction: returns to reset values at the next edge, regardless of pending increments.
- start_det or stop_det coincident with byte_valid: the byte is dropped and the START/STOP rule applies.

## Test plan
- Write 0xA0, 0x12, 0x3E, then 3 data bytes:
  - sel_start_addr once, start_addr=0x123E.
  - mem_we at 0x123E, 0x123F, 0x1200 (page wrap); final cur_addr=0x1201; slave_ack=1 on all 6 bytes.
- Random read: 0xA0, 0xFF, 0xFF, repeated START, 0xA1, then mack 1, 1, 0:
  - mem_re at 0xFFFF, 0x0000, 0x0001.
  - NACK → WAIT_STOP, no further strobes; stop → IDLE, busy=0.
- Control byte 0xA2 (wrong address): slave_ack=0, no strobes for following bytes until STOP; cur_addr unchanged.
- Write 0xA0, 0x40, then STOP: no sel_start_addr, cur_addr keeps prior value. A following 0xA1 read issues mem_re at that prior address.
- rst pulse between mem_we and incr_addr during a write at 0x0010: next cycle all outputs at reset values, cur_addr=0x0000, no incr_addr.
- stop_det and byte_valid in the same cycle in WR_DATA: no mem_we, state IDLE.
